dtop_sweeper: RTL and testbench
===============================

Name: dtop_sweeper

Overview:
Sequencer and response-capture stage wrapped around dtop.
- Upstream side: drives dtop's scin and cntrl buses. Holds scin at a seed word and steps cntrl from 0 to a programmable last value, dwelling a fixed number of cycles per step.
- Downstream side: folds each settled scout word into a 37-bit MISR signature.
- Replaces the free-running bench sweep with a synthesizable self-test engine.

Parameters:
- SC_W, 37, width of scin/scout/signature.
- CNTRL_W, 8, width of cntrl and last_cntrl.
- DWELL, 2, cycles cntrl is held per step before scout is sampled; legal range 1..15.
- POLY, 37'h0000000065, MISR feedback taps, XORed in when the MSB shifts out.

Ports:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, reset (asynchronous, active-low).
- start, in, 1, sweep request; sampled only in IDLE.
- seed, in, SC_W, scin value for the sweep; latched on accepted start.
- last_cntrl, in, CNTRL_W, final cntrl value; latched on accepted start.
- scin, out, SC_W, registered drive to dtop.scin.
- cntrl, out, CNTRL_W, registered drive to dtop.cntrl.
- scout, in, SC_W, dtop response.
- busy, out, 1, high from the cycle after an accepted start through the last sample cycle.
- done, out, 1, one-cycle pulse after the final sample.
- signature, out, SC_W, MISR value; stable from done until the next accepted start.
- step_count, out, CNTRL_W+1, number of samples folded so far.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; scin=0, cntrl=0, busy=0, done=0, signature=0, step_count=0, dwell counter=0.
- Reset mid-sweep aborts immediately to these values; no partial done.
- Release of reset is synchronous to clk.
- States: IDLE, RUN, DONE.

IDLE:
- Accepted start: scin<=seed; cntrl<=0; latch last_cntrl; signature<=0; step_count<=0; dwell<=0; ->RUN.
- busy is 1 from the next cycle.

RUN:
- dwell increments each cycle.
- When dwell==DWELL-1 (sample cycle):
  - signature <= {signature[SC_W-2:0],1'b0} ^ (signature[SC_W-1] ? POLY : 0) ^ scout.
  - step_count+=1.
  - If cntrl==latched last: ->DONE, cntrl held.
  - Else: cntrl<=cntrl+1, dwell<=0.
- First sample is DWELL cycles after the start edge.
- A sweep folds last_cntrl+1 samples in (last_cntrl+1)*DWELL RUN cycles.

DONE:
- done=1, busy=0 for exactly one cycle; ->IDLE.
- signature, scin, cntrl and step_count hold until the next accepted start.

Boundary and width rules:
- start while busy or in DONE is ignored; there is no queueing.
- seed and last_cntrl changing mid-sweep have no effect.
- last_cntrl=0: exactly one sample.
- last_cntrl=255: sweep stops at 255; cntrl never wraps; step_count=256 (hence width CNTRL_W+1).
- DWELL=1: sample every cycle; cntrl changes every cycle.
- The dwell counter is 4 bits.
- All arithmetic is unsigned; signature shift discards the MSB.

Test Plan:
- Reset, then start with seed=37'h1555555555, last_cntrl=63, DWELL=2, scout tied 0 -> scin=37'h1555555555; cntrl steps 0..63 every 2 cycles; busy 128 cycles; done pulse on cycle 129; signature=0; step_count=64.
- last_cntrl=0, scout=37'h5 -> one sample; signature=37'h5, step_count=1, done 3 cycles after start.
- last_cntrl=1, scout constant 37'h1 -> signature=37'h3 (shift 1, xor 1).
- last_cntrl=1, scout=37'h1000000000 during step 0 and 0 during step 1 -> signature=POLY (37'h65); checks MSB feedback.
- Pulse start again at cntrl=10 during a last_cntrl=63 sweep -> ignored; sweep and signature match an uninterrupted run.
- Assert rst_n low at cntrl=20 -> all outputs 0 immediately (asynchronously), no done. A fresh start then reproduces the golden signature of a bench model of dtop.

Source files
------------

// File: rtl/dtop_sweeper.sv
// Self-test sequencer around dtop: holds scin at a seed, steps cntrl 0..last,
// and folds each settled scout word into a MISR signature.
module dtop_sweeper #(
  parameter int             SC_W    = 37,
  parameter int             CNTRL_W = 8,
  parameter int             DWELL   = 2,
  parameter logic [SC_W-1:0] POLY   = 37'h0000000065
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SC_W-1:0]    seed,
  input  logic [CNTRL_W-1:0] last_cntrl,
  output logic [SC_W-1:0]    scin,
  output logic [CNTRL_W-1:0] cntrl,
  input  logic [SC_W-1:0]    scout,
  output logic               busy,
  output logic               done,
  output logic [SC_W-1:0]    signature,
  output logic [CNTRL_W:0]   step_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t             state;
  state_t             state_next;
  logic [3:0]         dwell;
  logic [CNTRL_W-1:0] last_q;
  logic               accept;
  logic               sample;
  logic               final_sample;
  logic [SC_W-1:0]    misr_next;

  assign accept       = (state == IDLE) && start;
  assign sample       = (state == RUN) && (dwell == DWELL_LAST);
  assign final_sample = sample && (cntrl == last_q);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // MSB is discarded by the shift; when it was set, the taps fold back in.
  always_comb begin
    misr_next = {signature[SC_W-2:0], 1'b0} ^ scout;
    if (signature[SC_W-1]) misr_next = misr_next ^ POLY;
  end

  // NOTE: state_next is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (final_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scin       <= '0;
      cntrl      <= '0;
      last_q     <= '0;
      signature  <= '0;
      step_count <= '0;
      dwell      <= '0;
    end else if (accept) begin
      scin       <= seed;
      cntrl      <= '0;
      last_q     <= last_cntrl;
      signature  <= '0;
      step_count <= '0;
      dwell      <= '0;
    end else if (sample) begin
      signature  <= misr_next;
      step_count <= step_count + (CNTRL_W + 1)'(1);
      if (!final_sample) begin
        cntrl <= cntrl + CNTRL_W'(1);
        dwell <= '0;
      end
    end else if (state == RUN) begin
      dwell <= dwell + 4'd1;
    end
  end

endmodule

// File: tb/tb_dtop_sweeper.sv
// Directed bench for dtop_sweeper: table of sweeps with hand-derived signatures
// plus reset-abort and ignored-restart sequences against a small dtop model.
module tb_dtop_sweeper;

  localparam int SC_W    = 37;
  localparam int CNTRL_W = 8;
  localparam int DWELL   = 2;
  localparam logic [SC_W-1:0] POLY = 37'h0000000065;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [SC_W-1:0]    seed;
  logic [CNTRL_W-1:0] last_cntrl;
  logic [SC_W-1:0]    scin;
  logic [CNTRL_W-1:0] cntrl;
  logic [SC_W-1:0]    scout;
  logic               busy;
  logic               done;
  logic [SC_W-1:0]    signature;
  logic [CNTRL_W:0]   step_count;

  int total = 0;
  int bad   = 0;

  logic            use_model;
  logic [SC_W-1:0] scout0;
  logic [SC_W-1:0] scout_rest;

  typedef struct {
    logic [SC_W-1:0]    seed;
    logic [CNTRL_W-1:0] last;
    logic               model;
    logic [SC_W-1:0]    s0;
    logic [SC_W-1:0]    srest;
    logic [SC_W-1:0]    exp_sig;
    int                 restart_k;
  } vec_t;

  vec_t vecs[8];

  dtop_sweeper #(
    .SC_W(SC_W), .CNTRL_W(CNTRL_W), .DWELL(DWELL), .POLY(POLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .last_cntrl(last_cntrl), .scin(scin), .cntrl(cntrl), .scout(scout),
    .busy(busy), .done(done), .signature(signature), .step_count(step_count)
  );

  always #5 clk = ~clk;

  function automatic logic [SC_W-1:0] dtop_model(logic [SC_W-1:0] s,
                                                 logic [CNTRL_W-1:0] c);
    logic [SC_W-1:0] r;
    r = {s[33:0], s[36:34]} ^ {29'h0, c};
    if (c[0]) r = r ^ 37'h1F0F0F0F0F;
    return r;
  endfunction

  function automatic logic [SC_W-1:0] misr(logic [SC_W-1:0] sig,
                                           logic [SC_W-1:0] d);
    logic [SC_W-1:0] r;
    r = {sig[SC_W-2:0], 1'b0} ^ d;
    if (sig[SC_W-1]) r = r ^ POLY;
    return r;
  endfunction

  function automatic logic [SC_W-1:0] golden(logic [SC_W-1:0] s,
                                             logic [CNTRL_W-1:0] last);
    logic [SC_W-1:0] sig = '0;
    for (int c = 0; c <= int'(last); c++) sig = misr(sig, dtop_model(s, CNTRL_W'(c)));
    return sig;
  endfunction

  always_comb begin
    if (use_model)       scout = dtop_model(scin, cntrl);
    else if (cntrl == 0) scout = scout0;
    else                 scout = scout_rest;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = (int'(v.last) + 1) * DWELL;
    use_model  = v.model;
    scout0     = v.s0;
    scout_rest = v.srest;
    seed       = v.seed;
    last_cntrl = v.last;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    seed       = ~v.seed;
    last_cntrl = ~v.last;
    for (int k = 1; k <= n; k++) begin
      check("busy_run", 64'(busy), 64'd1);
      check("done_run", 64'(done), 64'd0);
      check("cntrl_step", 64'(cntrl), 64'((k - 1) / DWELL));
      check("scin_hold", 64'(scin), 64'(v.seed));
      start = (k == v.restart_k);
      tick();
      start = 1'b0;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("signature", 64'(signature), 64'(v.exp_sig));
    check("step_count", 64'(step_count), 64'(int'(v.last) + 1));
    check("cntrl_final", 64'(cntrl), 64'(v.last));
    tick();
    check("done_clear", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("sig_hold", 64'(signature), 64'(v.exp_sig));
    check("scin_idle", 64'(scin), 64'(v.seed));
  endtask

  initial begin
    vecs[0] = '{37'h1555555555, 8'd63,  1'b0, 37'h0,          37'h0, 37'h0,  -1};
    vecs[1] = '{37'h0ABCDEF012, 8'd0,   1'b0, 37'h5,          37'h5, 37'h5,  -1};
    vecs[2] = '{37'h0000000001, 8'd1,   1'b0, 37'h1,          37'h1, 37'h3,  -1};
    vecs[3] = '{37'h1FFFFFFFFF, 8'd1,   1'b0, 37'h1000000000, 37'h0, 37'h65, -1};
    vecs[4] = '{37'h0000000000, 8'd2,   1'b0, 37'h1,          37'h1, 37'h7,  -1};
    vecs[5] = '{37'h0123456789, 8'd63,  1'b1, 37'h0,          37'h0,
                golden(37'h0123456789, 8'd63), 21};
    vecs[6] = '{37'h1234512345, 8'd255, 1'b0, 37'h0,          37'h0, 37'h0,  -1};
    vecs[7] = '{37'h0F00FF00F0, 8'd15,  1'b1, 37'h0,          37'h0,
                golden(37'h0F00FF00F0, 8'd15), -1};

    rst_n = 1'b0; start = 1'b0; seed = '0; last_cntrl = '0;
    use_model = 1'b0; scout0 = '0; scout_rest = '0;
    repeat (3) tick();
    check("rst_scin", 64'(scin), 64'd0);
    check("rst_cntrl", 64'(cntrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sig", 64'(signature), 64'd0);
    check("rst_steps", 64'(step_count), 64'd0);
    #3 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start in DONE must be ignored: one-sample sweep, hold start through done.
    use_model = 1'b0; scout0 = 37'h9; scout_rest = 37'h9;
    seed = 37'h11; last_cntrl = 8'd0; start = 1'b1;
    tick();
    tick();
    tick();
    check("start_in_done_sig", 64'(signature), 64'h9);
    check("start_in_done_pulse", 64'(done), 64'd1);
    start = 1'b0;
    tick();
    check("start_in_done_idle", 64'(busy), 64'd0);

    // Asynchronous abort mid-sweep.
    use_model = 1'b1; seed = 37'h0123456789; last_cntrl = 8'd63; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 200 && cntrl != 8'd20; b++) tick();
    check("reach_cntrl20", 64'(cntrl), 64'd20);
    #3 rst_n = 1'b0;
    #1;
    check("abort_scin", 64'(scin), 64'd0);
    check("abort_cntrl", 64'(cntrl), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sig", 64'(signature), 64'd0);
    check("abort_steps", 64'(step_count), 64'd0);
    tick();
    tick();
    check("abort_no_done", 64'(done), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_abort_done", 64'(done), 64'd0);
    vecs[5].restart_k = -1;
    run_vec(vecs[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
